// File: rtl/switch_pkg.sv
// Shared constants for the switch ingress path: FSM state encodings, framing
// sizes, descriptor field layout and the pad-length helper.
package switch_pkg;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PTR  = 3'd1;
  localparam logic [2:0] HDR  = 3'd2;
  localparam logic [2:0] PAY  = 3'd3;
  localparam logic [2:0] PAD  = 3'd4;
  localparam logic [2:0] GAP  = 3'd5;
  localparam logic [2:0] DROP = 3'd6;

  localparam int unsigned HDR_BYTES  = 16;
  localparam int unsigned CELL_BYTES = 16;
  localparam int unsigned GRP_BYTES  = 4 * CELL_BYTES;

  localparam int unsigned DESC_PM_MSB   = 15;
  localparam int unsigned DESC_PM_LSB   = 12;
  localparam int unsigned DESC_RSVD_BIT = 11;
  localparam int unsigned DESC_LEN_MSB  = 10;
  localparam int unsigned DESC_LEN_LSB  = 0;

  // Zero bytes needed after header + payload to reach the next 64-byte group.
  function automatic logic [5:0] pad_bytes(input logic [10:0] len);
    logic [11:0] sum;
    logic [11:0] total;
    sum   = 12'(HDR_BYTES) + {1'b0, len};
    total = (sum + 12'(GRP_BYTES - 1)) & ~12'(GRP_BYTES - 1);
    return 6'(total - sum);
  endfunction

endpackage

// File: rtl/switch_pre_fmt.sv
// Ingress framer feeding the cell packer: 16-byte header, payload, zero pad to 64 B.
// Optional length policing (DROP path + drop_cnt_inc) under SWITCH_PRE_FMT_LEN_CHECK_EN.
module switch_pre_fmt
  import switch_pkg::*;
#(
  parameter int unsigned MIN_GAP = 2,
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] ptr_fifo_din,
  input  logic        ptr_fifo_empty,
  output logic        ptr_fifo_rd,
  input  logic [7:0]  data_fifo_din,
  output logic        data_fifo_rd,
  input  logic        i_cell_bp,
  output logic        sof,
  output logic        dv,
`ifdef SWITCH_PRE_FMT_LEN_CHECK_EN
  output logic [7:0]  dout,
  output logic        drop_cnt_inc
`else
  output logic [7:0]  dout
`endif
);

  localparam int unsigned GW = $clog2(MIN_GAP + 1);

  logic [2:0]    r_state;
  logic [10:0]   r_len;
  logic [10:0]   r_cnt;
  logic [5:0]    r_pad;
  logic [GW-1:0] r_gap;
  logic          r_sof;
  logic          r_dv;
  logic [7:0]    r_dout;

  logic [10:0]   w_len;
  logic          w_start;
  logic          w_len_last;
  logic          w_unused_rsvd;

  assign w_len         = ptr_fifo_din[DESC_LEN_MSB:DESC_LEN_LSB];
  assign w_start       = (r_state == IDLE) && !ptr_fifo_empty && !i_cell_bp && (r_gap == '0);
  assign w_len_last    = (r_cnt == r_len - 11'd1);
  assign w_unused_rsvd = ptr_fifo_din[DESC_RSVD_BIT];

  assign ptr_fifo_rd = w_start;
  assign sof         = r_sof;
  assign dv          = r_dv;
  assign dout        = r_dout;

`ifdef SWITCH_PRE_FMT_LEN_CHECK_EN
  logic r_drop;
  logic w_len_bad;
  assign w_len_bad    = (w_len < 11'(MIN_LEN)) || (w_len > 11'(MAX_LEN));
  assign drop_cnt_inc = r_drop;
`else
  logic w_unused_len_cfg;
  assign w_unused_len_cfg = (MIN_LEN > MAX_LEN);
`endif

  // Pops run one cycle ahead of the registered output byte they feed.
  always_comb begin
    data_fifo_rd = ((r_state == HDR) && (r_cnt == 11'(HDR_BYTES - 1))) ||
                   ((r_state == PAY) && !w_len_last);
`ifdef SWITCH_PRE_FMT_LEN_CHECK_EN
    if (r_state == DROP) data_fifo_rd = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_pad   <= '0;
      r_gap   <= GW'(MIN_GAP);
      r_sof   <= 1'b0;
      r_dv    <= 1'b0;
      r_dout  <= '0;
`ifdef SWITCH_PRE_FMT_LEN_CHECK_EN
      r_drop  <= 1'b0;
`endif
    end else begin
      r_sof  <= 1'b0;
      r_dv   <= 1'b0;
      r_dout <= '0;
`ifdef SWITCH_PRE_FMT_LEN_CHECK_EN
      r_drop <= 1'b0;
`endif
      if (r_gap != '0) r_gap <= r_gap - GW'(1);

      case (r_state)
        IDLE: if (w_start) r_state <= PTR;

        // Header byte 0 is built straight from the descriptor so sof lands
        // two cycles after the start decision.
        PTR: begin
          r_len <= w_len;
          r_pad <= pad_bytes(w_len);
          r_cnt <= '0;
          if (w_len == '0) begin
            r_state <= GAP;
            r_gap   <= GW'(MIN_GAP);
          end
`ifdef SWITCH_PRE_FMT_LEN_CHECK_EN
          else if (w_len_bad) begin
            r_state <= DROP;
          end
`endif
          else begin
            r_state <= HDR;
            r_cnt   <= 11'd1;
            r_sof   <= 1'b1;
            r_dv    <= 1'b1;
            r_dout  <= {4'b0, ptr_fifo_din[DESC_PM_MSB:DESC_PM_LSB]};
          end
        end

        HDR: begin
          r_dv <= 1'b1;
          case (r_cnt[3:0])
            4'd1:    r_dout <= {5'b0, r_len[10:8]};
            4'd2:    r_dout <= r_len[7:0];
            default: ;
          endcase
          if (r_cnt == 11'(HDR_BYTES - 1)) begin
            r_state <= PAY;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end

        PAY: begin
          r_dv   <= 1'b1;
          r_dout <= data_fifo_din;
          if (w_len_last) begin
            r_cnt <= '0;
            if (r_pad != '0) begin
              r_state <= PAD;
            end else begin
              r_state <= GAP;
              r_gap   <= GW'(MIN_GAP);
            end
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end

        PAD: begin
          r_dv <= 1'b1;
          if (r_cnt == {5'b0, r_pad} - 11'd1) begin
            r_state <= GAP;
            r_gap   <= GW'(MIN_GAP);
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end

        GAP: if (r_gap <= GW'(1)) r_state <= IDLE;

`ifdef SWITCH_PRE_FMT_LEN_CHECK_EN
        DROP: begin
          if (w_len_last) begin
            r_state <= GAP;
            r_gap   <= GW'(MIN_GAP);
            r_drop  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 11'd1;
          end
        end
`endif

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
